mux4_rr_arbiter: RTL and testbench



---
 rtl/mux4_rr_arbiter.sv | 115 +++++++++++
 tb/tb_mux4_rr_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the select lines of a 4:1 bit mux.
// Define MUX4_ARB_HOLD_LIMIT_EN to force rotation after MAX_HOLD cycles of contended tenure.
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] REQ,
    output logic [3:0] GNT,
    output logic       S0,
    output logic       S1,
    output logic       BUSY
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e     state_q, state_d;
    logic [1:0] own_q, own_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;

    logic [3:0] cand;
    logic [1:0] idx;
    logic [1:0] winner;
    logic       win_valid;
    logic       hold_expired;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must be in 1..255");
    end

`ifdef MUX4_ARB_HOLD_LIMIT_EN
    assign hold_expired = (cnt_q >= 8'(MAX_HOLD));
`else
    assign hold_expired = 1'b0;
`endif

    // While granted, the current owner is never a candidate for the next winner.
    always_comb begin
        cand = REQ;
        if (state_q == StGrant) begin
            cand = REQ & ~(4'b0001 << own_q);
        end
    end

    always_comb begin
        winner    = own_q;
        win_valid = 1'b0;
        idx       = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!win_valid && cand[idx]) begin
                winner    = idx;
                win_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            own_q   <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    state_d = StGrant;
                    own_d   = winner;
                    ptr_d   = winner + 2'd1;
                    cnt_d   = 8'd1;
                end
            end
            StGrant: begin
                if (!REQ[own_q] || (hold_expired && win_valid)) begin
                    if (win_valid) begin
                        own_d = winner;
                        ptr_d = winner + 2'd1;
                        cnt_d = 8'd1;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Select lines keep the last owner in idle so the mux output stays stable.
    always_comb begin
        GNT  = 4'b0000;
        BUSY = 1'b0;
        if (state_q == StGrant) begin
            GNT  = 4'b0001 << own_q;
            BUSY = 1'b1;
        end
        {S1, S0} = own_q;
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed test-plan steps plus randomized REQ
// traffic checked against a behavioural round-robin model and a behavioural mux4.
module tb_mux4_rr_arbiter;

    localparam int unsigned MaxHold = 3;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
    localparam bit HoldOn = 1'b1;
`else
    localparam bit HoldOn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic       s0, s1, busy;
    logic [3:0] mux_in = 4'b1011;  // I3..I0 = 1,0,1,1
    logic       y;

    int n_cmp = 0;
    int n_err = 0;

    bit m_busy;
    int m_own, m_ptr, m_cnt;

    mux4_rr_arbiter #(.MAX_HOLD(MaxHold)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .REQ  (req),
        .GNT  (gnt),
        .S0   (s0),
        .S1   (s1),
        .BUSY (busy)
    );

    always #5 clk = ~clk;

    assign y = mux_in[{s1, s0}];

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int from, input int skip);
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (from + k) % 4;
            if (r[c] && c != skip) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_own  = 0;
        m_ptr  = 0;
        m_cnt  = 0;
    endtask

    task automatic model_grant(input int w);
        m_busy = 1'b1;
        m_own  = w;
        m_ptr  = (w + 1) % 4;
        m_cnt  = 1;
    endtask

    task automatic model_edge(input logic [3:0] r);
        int w;
        if (!m_busy) begin
            w = pick(r, m_ptr, -1);
            if (w >= 0) model_grant(w);
        end else begin
            w = pick(r, m_ptr, m_own);
            if (!r[m_own]) begin
                if (w >= 0) model_grant(w);
                else m_busy = 1'b0;
            end else if (HoldOn && m_cnt >= int'(MaxHold) && w >= 0) begin
                model_grant(w);
            end else if (m_cnt < 255) begin
                m_cnt++;
            end
        end
    endtask

    task automatic check_model();
        logic [3:0] exp_gnt;
        logic [1:0] exp_sel;
        exp_gnt = m_busy ? 4'(1 << m_own) : 4'b0000;
        exp_sel = 2'(m_own);
        chk("gnt", gnt, exp_gnt);
        chk("sel", {2'b00, s1, s0}, {2'b00, exp_sel});
        chk("busy", {3'b000, busy}, {3'b000, m_busy});
        chk("onehot0", {3'b000, $onehot0(gnt)}, 4'b0001);
        if (m_busy) chk("mux_y", {3'b000, y}, {3'b000, mux_in[m_own]});
    endtask

    task automatic step(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        check_model();
    endtask

    initial begin
        logic [3:0] r;
        logic [3:0] exp_g;

        model_reset();
        #12;
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_sel_busy", {1'b0, s1, s0, busy}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with no requests.
        for (int i = 0; i < 5; i++) begin
            step(4'b0000);
            chk("idle_gnt", gnt, 4'b0000);
            chk("idle_sel_busy", {1'b0, s1, s0, busy}, 4'b0000);
        end

        // Full contention, each owner drops its bit after two cycles of tenure.
        step(4'b1111);
        chk("rot_first", gnt, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            step(4'b1111);
            chk("rot_keep", gnt, 4'(1 << (k % 4)));
            step(4'b1111 & ~4'(1 << (k % 4)));
            exp_g = 4'(1 << ((k + 1) % 4));
            chk("rot_next", gnt, exp_g);
            chk("rot_busy_sel", {1'b0, busy, s1, s0}, {2'b01, 2'((k + 1) % 4)});
            chk("rot_y", {3'b000, y}, {3'b000, mux_in[(k + 1) % 4]});
        end

        // Lone requester, then release keeps the select lines.
        step(4'b0000);
        step(4'b0100);
        chk("lone_gnt", gnt, 4'b0100);
        chk("lone_sel", {2'b00, s1, s0}, 4'b0010);
        step(4'b0000);
        chk("lone_rel_gnt", gnt, 4'b0000);
        chk("lone_rel_sel_busy", {1'b0, s1, s0, busy}, 4'b0100);

        // Asynchronous reset while requester 3 owns the grant.
        step(4'b1000);
        chk("pre_rst_gnt", gnt, 4'b1000);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_gnt", gnt, 4'b0000);
        chk("async_rst_sel_busy", {1'b0, s1, s0, busy}, 4'b0000);
        model_reset();
        req = 4'b1001;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1001);
        chk("post_rst_gnt", gnt, 4'b0001);

        // Two requesters held constantly: hold limit decides rotation.
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 12; j++) begin
            step(4'b0011);
            exp_g = (HoldOn && ((j / 3) % 2 == 1)) ? 4'b0010 : 4'b0001;
            chk("hold_gnt", gnt, exp_g);
        end

        // Randomized traffic against the model.
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            step(r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
